lab2_proc_fetch_unit: RTL and testbench

LAB2_PROC_FETCH_UNIT -- requirements
Module: lab2_proc_fetch_unit

---
 rtl/lab2_proc_fetch_unit_if.sv | 38 +++
 rtl/lab2_proc_fetch_unit.sv | 117 +++++++++++
 tb/tb_lab2_proc_fetch_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lab2_proc_fetch_unit_if.sv
// Bundles the fetch unit's memory request/response, redirect, instruction and status signals.
// The master modport is the fetch unit; the slave modport is its environment.
interface lab2_proc_fetch_unit_if #(
  parameter int unsigned p_addr_nbits  = 32,
  parameter int unsigned p_data_nbits  = 32,
  parameter int unsigned p_num_entries = 4
);
  localparam int unsigned CW = $clog2(p_num_entries) + 1;

  logic                    imem_req_val;
  logic                    imem_req_rdy;
  logic [p_addr_nbits-1:0] imem_req_addr;
  logic                    imem_resp_val;
  logic                    imem_resp_rdy;
  logic [p_data_nbits-1:0] imem_resp_data;
  logic                    redirect_val;
  logic [p_addr_nbits-1:0] redirect_pc;
  logic                    inst_val;
  logic                    inst_rdy;
  logic [p_data_nbits-1:0] inst_data;
  logic [p_addr_nbits-1:0] inst_pc;
  logic [CW-1:0]           inflight_count;
  logic [CW-1:0]           queue_count;

  modport master (
    output imem_req_val, imem_req_addr, imem_resp_rdy,
    output inst_val, inst_data, inst_pc, inflight_count, queue_count,
    input  imem_req_rdy, imem_resp_val, imem_resp_data,
    input  redirect_val, redirect_pc, inst_rdy
  );

  modport slave (
    input  imem_req_val, imem_req_addr, imem_resp_rdy,
    input  inst_val, inst_data, inst_pc, inflight_count, queue_count,
    output imem_req_rdy, imem_resp_val, imem_resp_data,
    output redirect_val, redirect_pc, inst_rdy
  );
endinterface

// File: rtl/lab2_proc_fetch_unit.sv
// Credit-limited instruction fetch unit: issues PC-sequential requests, pairs in-order
// responses with their PC tags, queues them for decode and squashes stale work on redirect.
module lab2_proc_fetch_unit #(
  parameter int unsigned                p_addr_nbits   = 32,
  parameter int unsigned                p_data_nbits   = 32,
  parameter logic [p_addr_nbits-1:0]    p_reset_vector = 32'h200,
  parameter int unsigned                p_num_entries  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  lab2_proc_fetch_unit_if.master        bus
);
  localparam int unsigned PW = $clog2(p_num_entries);
  localparam int unsigned CW = PW + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t NUM = cnt_t'(p_num_entries);

  logic [p_addr_nbits-1:0] pc_q, pc_d;
  cnt_t                    inflight_q, inflight_d;
  cnt_t                    drop_q, drop_d;
  cnt_t                    qcnt_q, qcnt_d;
  logic [PW-1:0]           tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [PW-1:0]           iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;

  logic [p_addr_nbits-1:0] tag_mem_q [p_num_entries];
  logic [p_addr_nbits-1:0] iq_pc_q   [p_num_entries];
  logic [p_data_nbits-1:0] iq_data_q [p_num_entries];

  logic [CW:0] occupancy;
  logic        req_val, req_fire;
  logic        resp_fire, resp_live, resp_keep;
  logic        inst_val, inst_pop;

  // Every request holds a credit until its instruction leaves the queue, so accepted
  // responses always find room.
  assign occupancy = {1'b0, inflight_q} + {1'b0, qcnt_q};
  assign req_val   = reset & ~bus.redirect_val & (occupancy < {1'b0, NUM});
  assign req_fire  = req_val & bus.imem_req_rdy;
  assign resp_fire = bus.imem_resp_val & reset;
  assign resp_live = resp_fire & (inflight_q != '0);
  assign resp_keep = resp_live & (drop_q == '0) & ~bus.redirect_val;
  assign inst_val  = reset & (qcnt_q != '0) & ~bus.redirect_val;
  assign inst_pop  = inst_val & bus.inst_rdy;

  // Next-state for PC, counters and FIFO pointers.
  always_comb begin
    pc_d       = pc_q;
    drop_d     = drop_q;
    qcnt_d     = qcnt_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    iq_wr_d    = iq_wr_q;
    iq_rd_d    = iq_rd_q;
    inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(resp_live);
    if (bus.redirect_val) begin
      // Everything still outstanding after this cycle is stale, dropped or not.
      pc_d     = bus.redirect_pc;
      drop_d   = inflight_q - cnt_t'(resp_live);
      qcnt_d   = '0;
      tag_wr_d = '0;
      tag_rd_d = '0;
      iq_wr_d  = '0;
      iq_rd_d  = '0;
    end else begin
      pc_d     = req_fire ? pc_q + p_addr_nbits'(4) : pc_q;
      drop_d   = (resp_live && (drop_q != '0)) ? drop_q - cnt_t'(1) : drop_q;
      tag_wr_d = tag_wr_q + PW'(req_fire);
      tag_rd_d = tag_rd_q + PW'(resp_keep);
      iq_wr_d  = iq_wr_q + PW'(resp_keep);
      iq_rd_d  = iq_rd_q + PW'(inst_pop);
      qcnt_d   = qcnt_q + cnt_t'(resp_keep) - cnt_t'(inst_pop);
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= p_reset_vector;
      inflight_q <= '0;
      drop_q     <= '0;
      qcnt_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      iq_wr_q    <= '0;
      iq_rd_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      qcnt_q     <= qcnt_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      iq_wr_q    <= iq_wr_d;
      iq_rd_q    <= iq_rd_d;
    end
  end

  // Storage arrays; contents are only meaningful between the reset-cleared pointers.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_mem_q[tag_wr_q] <= pc_q;
    end
    if (resp_keep) begin
      iq_pc_q[iq_wr_q]   <= tag_mem_q[tag_rd_q];
      iq_data_q[iq_wr_q] <= bus.imem_resp_data;
    end
  end

  assign bus.imem_req_val   = req_val;
  assign bus.imem_req_addr  = pc_q;
  assign bus.imem_resp_rdy  = reset;
  assign bus.inst_val       = inst_val;
  assign bus.inst_data      = iq_data_q[iq_rd_q];
  assign bus.inst_pc        = iq_pc_q[iq_rd_q];
  assign bus.inflight_count = inflight_q;
  assign bus.queue_count    = qcnt_q;
endmodule

// File: tb/tb_lab2_proc_fetch_unit.sv
// Directed bench for the fetch unit: an in-order 1-cycle memory model with a response-hold control,
// an expected-PC scoreboard filled by the stimulus and drained by an instruction monitor.
module tb_lab2_proc_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lab2_proc_fetch_unit_if #(.p_addr_nbits(32), .p_data_nbits(32), .p_num_entries(4)) bus ();

  lab2_proc_fetch_unit #(
    .p_addr_nbits(32), .p_data_nbits(32), .p_reset_vector(32'h200), .p_num_entries(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic        mem_hold;
  logic [31:0] pend [$];
  int          req_count = 0;
  logic [31:0] sb [$];
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // In-order memory: answers the oldest pending request one cycle after it fires.
  always @(posedge clk) begin
    if (!reset) begin
      pend.delete();
      bus.imem_resp_val  <= 1'b0;
      bus.imem_resp_data <= 32'h0;
    end else begin
      if (bus.imem_resp_val && bus.imem_resp_rdy && pend.size() > 0) void'(pend.pop_front());
      if (bus.imem_req_val && bus.imem_req_rdy) begin
        pend.push_back(bus.imem_req_addr);
        req_count++;
      end
      if (!mem_hold && pend.size() > 0) begin
        bus.imem_resp_val  <= 1'b1;
        bus.imem_resp_data <= mem_word(pend[0]);
      end else begin
        bus.imem_resp_val  <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b0;
    bus.redirect_val = 1'b0;
    bus.redirect_pc  = 32'h0;
    bus.imem_req_rdy = 1'b1;
    bus.inst_rdy     = 1'b0;
    mem_hold         = 1'b0;
    step();
  endtask

  task automatic monitor();
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b1 && bus.inst_val === 1'b1 && bus.inst_rdy === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL inst_unexpected: got pc 0x%08h, expected no instruction", bus.inst_pc);
        end else begin
          exp = sb.pop_front();
          chk("inst_pc", bus.inst_pc, exp);
          chk("inst_data", bus.inst_data, mem_word(exp));
        end
      end
    end
  endtask

  int base;

  initial begin
    reset = 1'b0;
    bus.redirect_val = 1'b0;
    bus.redirect_pc  = 32'h0;
    bus.imem_req_rdy = 1'b1;
    bus.inst_rdy     = 1'b0;
    mem_hold         = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) step();
    #1;
    chk("rst_req_val", 32'(bus.imem_req_val), 32'd0);
    chk("rst_resp_rdy", 32'(bus.imem_resp_rdy), 32'd0);
    chk("rst_inst_val", 32'(bus.inst_val), 32'd0);
    chk("rst_inflight", 32'(bus.inflight_count), 32'd0);
    chk("rst_queue", 32'(bus.queue_count), 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h200);

    // Straight-line: eight instructions pop on eight consecutive cycles after a 2-cycle fill
    step();
    reset = 1'b1; bus.inst_rdy = 1'b1;
    for (int k = 0; k < 8; k++) sb.push_back(32'h200 + 32'(4 * k));
    repeat (10) step();
    bus.inst_rdy = 1'b0;
    #1;
    chk("straight_drain", 32'(sb.size()), 32'd0);

    // Backpressure: four credits, then one pop frees exactly one request
    do_reset();
    reset = 1'b1;
    base = req_count;
    repeat (10) step();
    #1;
    chk("bp_req_count", 32'(req_count - base), 32'd4);
    chk("bp_queue", 32'(bus.queue_count), 32'd4);
    chk("bp_inflight", 32'(bus.inflight_count), 32'd0);
    chk("bp_req_val", 32'(bus.imem_req_val), 32'd0);
    sb.push_back(32'h200);
    bus.inst_rdy = 1'b1;
    step();
    bus.inst_rdy = 1'b0;
    #1;
    chk("bp_queue_after_pop", 32'(bus.queue_count), 32'd3);
    chk("bp_req_val_after_pop", 32'(bus.imem_req_val), 32'd1);
    chk("bp_req_addr", bus.imem_req_addr, 32'h210);
    step();
    #1;
    chk("bp_req_count_after", 32'(req_count - base), 32'd5);
    bus.redirect_val = 1'b1; bus.redirect_pc = 32'h2000;
    #1;
    chk("redir_inst_val_forced", 32'(bus.inst_val), 32'd0);
    chk("redir_req_val_forced", 32'(bus.imem_req_val), 32'd0);
    step();
    bus.redirect_val = 1'b0;
    #1;
    chk("redir_queue_cleared", 32'(bus.queue_count), 32'd0);
    chk("bp_drain", 32'(sb.size()), 32'd0);

    // Redirect with two requests in flight
    do_reset();
    reset = 1'b1; mem_hold = 1'b1; bus.inst_rdy = 1'b1;
    repeat (2) step();
    bus.imem_req_rdy = 1'b0;
    #1;
    chk("r2_inflight", 32'(bus.inflight_count), 32'd2);
    step();
    bus.redirect_val = 1'b1; bus.redirect_pc = 32'h1000; bus.imem_req_rdy = 1'b1;
    step();
    bus.redirect_val = 1'b0; mem_hold = 1'b0;
    sb.push_back(32'h1000); sb.push_back(32'h1004);
    #1;
    chk("r2_inflight_kept", 32'(bus.inflight_count), 32'd2);
    chk("r2_req_addr", bus.imem_req_addr, 32'h1000);
    repeat (2) step();
    bus.imem_req_rdy = 1'b0;
    #1;
    chk("r2_drop_first", 32'(bus.queue_count), 32'd0);
    step();
    #1;
    chk("r2_drop_second", 32'(bus.queue_count), 32'd0);
    repeat (6) step();
    #1;
    chk("r2_drain", 32'(sb.size()), 32'd0);
    chk("r2_inflight_end", 32'(bus.inflight_count), 32'd0);

    // Redirect coinciding with the only outstanding response
    do_reset();
    reset = 1'b1; mem_hold = 1'b1; bus.inst_rdy = 1'b1;
    step();
    bus.imem_req_rdy = 1'b0; mem_hold = 1'b0;
    step();
    bus.redirect_val = 1'b1; bus.redirect_pc = 32'h3000;
    #1;
    chk("sim_inflight_before", 32'(bus.inflight_count), 32'd1);
    step();
    bus.redirect_val = 1'b0; bus.imem_req_rdy = 1'b1;
    sb.push_back(32'h3000);
    #1;
    chk("sim_inflight_after", 32'(bus.inflight_count), 32'd0);
    chk("sim_queue_after", 32'(bus.queue_count), 32'd0);
    step();
    bus.imem_req_rdy = 1'b0;
    repeat (5) step();
    #1;
    chk("sim_drain", 32'(sb.size()), 32'd0);

    // PC wrap-around at the top of the address space
    do_reset();
    reset = 1'b1; bus.imem_req_rdy = 1'b0; bus.inst_rdy = 1'b1;
    bus.redirect_val = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect_val = 1'b0; bus.imem_req_rdy = 1'b1;
    sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0000_0000);
    #1;
    chk("wrap_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    repeat (2) step();
    bus.imem_req_rdy = 1'b0;
    #1;
    chk("wrap_pc_next", bus.imem_req_addr, 32'h0000_0004);
    repeat (6) step();
    #1;
    chk("wrap_drain", 32'(sb.size()), 32'd0);

    // Reset in the middle of a run abandons everything
    do_reset();
    reset = 1'b1;
    repeat (4) step();
    #1;
    chk("mid_queue_before", 32'(bus.queue_count), 32'd3);
    chk("mid_inflight_before", 32'(bus.inflight_count), 32'd1);
    reset = 1'b0;
    step();
    #1;
    chk("mid_inflight", 32'(bus.inflight_count), 32'd0);
    chk("mid_queue", 32'(bus.queue_count), 32'd0);
    chk("mid_req_addr", bus.imem_req_addr, 32'h200);
    chk("mid_inst_val", 32'(bus.inst_val), 32'd0);
    chk("mid_req_val", 32'(bus.imem_req_val), 32'd0);
    reset = 1'b1; bus.inst_rdy = 1'b1;
    sb.push_back(32'h200);
    step();
    bus.imem_req_rdy = 1'b0;
    repeat (6) step();
    #1;
    chk("mid_drain", 32'(sb.size()), 32'd0);
    chk("mid_inflight_end", 32'(bus.inflight_count), 32'd0);
    chk("mid_queue_end", 32'(bus.queue_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
